// File: rtl/instr_fetch_sequencer_if.sv
// Bundle of the fetch sequencer's control, memory and register-load signals.
//   master : the sequencer. It takes Start, PC, MemData and MemAck and drives
//            the memory request, the IR/PC load controls and the status pulses.
//   slave  : the surrounding datapath, memory and control unit.
interface instr_fetch_sequencer_if;
    logic        Start;
    logic [15:0] PC;
    logic [7:0]  MemData;
    logic        MemAck;
    logic [15:0] MemAddr;
    logic        MemReq;
    logic [15:0] IR_I;
    logic [2:0]  IR_FunSel;
    logic        IR_E;
    logic [2:0]  PC_FunSel;
    logic        PC_E;
    logic        Busy;
    logic        Done;
    logic        Timeout;

    modport master (
        input  Start, PC, MemData, MemAck,
        output MemAddr, MemReq, IR_I, IR_FunSel, IR_E, PC_FunSel, PC_E,
               Busy, Done, Timeout
    );

    modport slave (
        output Start, PC, MemData, MemAck,
        input  MemAddr, MemReq, IR_I, IR_FunSel, IR_E, PC_FunSel, PC_E,
               Busy, Done, Timeout
    );
endinterface

// File: rtl/instr_fetch_sequencer.sv
// Fetches one 16-bit instruction as two bytes (PC, then PC+1) from byte-wide
// memory and loads them into the instruction register, low byte first.
// The PC register is incremented after each byte.
//   Clock  : rising-edge clock
//   Reset  : asynchronous, active-low
//   bus    : master modport. Inputs are Start, PC, MemData and MemAck.
//            Outputs are MemAddr/MemReq, IR_I/IR_FunSel/IR_E,
//            PC_FunSel/PC_E and Busy/Done/Timeout.
// With TIMEOUT != 0, a byte that gets no MemAck within TIMEOUT request
// cycles aborts the fetch and raises a single Timeout pulse.
module instr_fetch_sequencer #(
    parameter int TIMEOUT = 15,
    parameter int CNT_W   = 4
) (
    input  logic                    Clock,
    input  logic                    Reset,
    instr_fetch_sequencer_if.master bus
);
    typedef enum logic [2:0] {
        S_IDLE, S_REQ_LO, S_LOAD_LO, S_REQ_HI, S_LOAD_HI, S_DONE, S_ABORT
    } state_t;

    localparam bit               TO_EN   = (TIMEOUT != 0);
    // Value of cnt_q in the last request cycle allowed before abort.
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [7:0]       byte_q, byte_d;

    logic [15:0] mem_addr;
    logic        mem_req, ir_e, pc_e, done, tout;
    logic [2:0]  ir_fs, pc_fs;

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            byte_q  <= 8'h00;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            byte_q  <= byte_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        byte_d   = byte_q;
        mem_req  = 1'b0;
        mem_addr = 16'h0000;
        ir_e     = 1'b0;
        ir_fs    = 3'b000;
        pc_e     = 1'b0;
        pc_fs    = 3'b000;
        done     = 1'b0;
        tout     = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (bus.Start) begin
                    state_d = S_REQ_LO;
                    cnt_d   = '0;
                end
            end
            S_REQ_LO, S_REQ_HI: begin
                mem_req  = 1'b1;
                // REQ_HI sees the PC already incremented by LOAD_LO, so no adder here.
                mem_addr = bus.PC;
                if (bus.MemAck) begin
                    byte_d  = bus.MemData;
                    state_d = (state_q == S_REQ_LO) ? S_LOAD_LO : S_LOAD_HI;
                end else if (TO_EN && cnt_q == TO_LAST) begin
                    state_d = S_ABORT;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_LOAD_LO: begin
                ir_e    = 1'b1;
                ir_fs   = 3'b101;
                pc_e    = 1'b1;
                pc_fs   = 3'b001;
                state_d = S_REQ_HI;
                cnt_d   = '0;
            end
            S_LOAD_HI: begin
                ir_e    = 1'b1;
                ir_fs   = 3'b110;
                pc_e    = 1'b1;
                pc_fs   = 3'b001;
                state_d = S_DONE;
            end
            S_DONE: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            S_ABORT: begin
                tout    = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign bus.MemAddr   = mem_addr;
    assign bus.MemReq    = mem_req;
    assign bus.IR_I      = {8'h00, byte_q};
    assign bus.IR_FunSel = ir_fs;
    assign bus.IR_E      = ir_e;
    assign bus.PC_FunSel = pc_fs;
    assign bus.PC_E      = pc_e;
    assign bus.Busy      = (state_q != S_IDLE);
    assign bus.Done      = done;
    assign bus.Timeout   = tout;
endmodule

// File: tb/tb_instr_fetch_sequencer.sv
module tb_instr_fetch_sequencer;
    localparam int TO = 15;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    instr_fetch_sequencer_if bus();
    instr_fetch_sequencer #(.TIMEOUT(TO), .CNT_W(4)) dut (
        .Clock(clk), .Reset(rst_n), .bus(bus)
    );

    int total = 0;
    int bad = 0;

    // Memory contents, plus PC and IR register models driven by the DUT's load controls.
    logic [7:0]  mem [0:65535];
    logic [15:0] pc_m = 16'h0000;
    logic [15:0] ir_m = 16'h0000;
    logic        pc_ld = 1'b0;
    logic [15:0] pc_ld_val = 16'h0000;
    assign bus.PC = pc_m;

    always @(posedge clk) begin
        if (pc_ld) pc_m <= pc_ld_val;
        else if (bus.PC_E && bus.PC_FunSel == 3'b001) pc_m <= pc_m + 16'd1;
        if (bus.IR_E && bus.IR_FunSel == 3'b101) ir_m[7:0]  <= bus.IR_I[7:0];
        if (bus.IR_E && bus.IR_FunSel == 3'b110) ir_m[15:8] <= bus.IR_I[7:0];
    end

    // Memory responder. It acks after w_lo/w_hi wait cycles, and with noise on
    // it pulses junk acks whenever no request is pending.
    int          w_lo = 0;
    int          w_hi = 0;
    int          rcnt = 0;
    logic [15:0] base = 16'h0000;
    bit          noise = 1'b0;
    always @(negedge clk) begin
        if (bus.MemReq) begin
            rcnt <= rcnt + 1;
            if (rcnt == ((bus.MemAddr == base) ? w_lo : w_hi)) begin
                bus.MemAck  <= 1'b1;
                bus.MemData <= mem[bus.MemAddr];
            end else begin
                bus.MemAck  <= 1'b0;
                bus.MemData <= 8'($urandom);
            end
        end else begin
            rcnt <= 0;
            if (noise && $urandom_range(0, 2) == 0) begin
                bus.MemAck  <= 1'b1;
                bus.MemData <= 8'($urandom);
            end else begin
                bus.MemAck  <= 1'b0;
                bus.MemData <= 8'h00;
            end
        end
    end

    logic [7:0] last_b = 8'h00;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    function automatic logic [43:0] obs_vec();
        return {bus.MemAddr, bus.MemReq, bus.IR_I, bus.IR_FunSel, bus.IR_E,
                bus.PC_FunSel, bus.PC_E, bus.Busy, bus.Done, bus.Timeout};
    endfunction

    // Phase codes: 0 idle, 1 request low, 2 load low, 3 request high,
    // 4 load high, 5 done, 6 abort.
    function automatic logic [43:0] exp_vec(input int ph, input logic [15:0] p, input logic [7:0] irb);
        logic [15:0] a = 16'h0000;
        logic        rq = 1'b0, ire = 1'b0, pce = 1'b0, b = 1'b0, d = 1'b0, t = 1'b0;
        logic [2:0]  irf = 3'b000, pcf = 3'b000;
        case (ph)
            1: begin rq = 1'b1; a = p; b = 1'b1; end
            2: begin ire = 1'b1; irf = 3'b101; pce = 1'b1; pcf = 3'b001; b = 1'b1; end
            3: begin rq = 1'b1; a = p + 16'd1; b = 1'b1; end
            4: begin ire = 1'b1; irf = 3'b110; pce = 1'b1; pcf = 3'b001; b = 1'b1; end
            5: begin d = 1'b1; b = 1'b1; end
            6: begin t = 1'b1; b = 1'b1; end
            default: ;
        endcase
        return {a, rq, 8'h00, irb, irf, ire, pcf, pce, b, d, t};
    endfunction

    // One fetch from PC p. wl/wh are the memory wait cycles (>= TO means no ack).
    // If rst_at > 0, reset is asserted during that cycle.
    task automatic fetch(input logic [15:0] p, input int wl, input int wh,
                         input bit nz, input int rst_at);
        bit          lo_ok, hi_ok, got_lo, got_hi;
        int          a, h, n, ph;
        logic [7:0]  lob, hib, irb;
        logic [15:0] old_ir, exp_pc, exp_ir;
        pc_ld = 1'b1; pc_ld_val = p;
        @(negedge clk);
        pc_ld = 1'b0;
        base = p; w_lo = wl; w_hi = wh; noise = nz;
        old_ir = ir_m;
        lob = mem[p]; hib = mem[p + 16'd1];
        lo_ok = (wl < TO); hi_ok = (wh < TO);
        a = lo_ok ? wl + 1 : TO;
        h = hi_ok ? wh + 1 : TO;
        n = !lo_ok ? a + 1 : (hi_ok ? a + h + 3 : a + h + 2);
        bus.Start = 1'b1;
        @(negedge clk);
        for (int c = 1; c <= n + 1; c++) begin
            if (c > n)              ph = 0;
            else if (c <= a)        ph = lo_ok || c <= TO ? 1 : 6;
            else if (!lo_ok)        ph = 6;
            else if (c == a + 1)    ph = 2;
            else if (c <= a + 1 + h) ph = 3;
            else if (!hi_ok)        ph = 6;
            else if (c == a + h + 2) ph = 4;
            else                    ph = 5;
            got_lo = lo_ok && c > a;
            got_hi = lo_ok && hi_ok && c > a + 1 + h;
            irb = got_hi ? hib : (got_lo ? lob : last_b);
            chk($sformatf("cyc%0d@%h", c, p), 44'(obs_vec()), 44'(exp_vec(ph, p, irb)));
            if (c == rst_at) begin
                #2 rst_n = 1'b0;
                #1 chk("async_rst", 44'(obs_vec()), 44'd0);
                bus.Start = 1'b0;
                repeat (2) begin
                    @(negedge clk);
                    chk("in_rst", 44'(obs_vec()), 44'd0);
                end
                rst_n = 1'b1;
                last_b = 8'h00;
                chk("rst_pc", 64'(pc_m), 64'(got_lo ? p + 16'd1 : p));
                chk("rst_ir_lo", 64'(ir_m[7:0]), 64'(got_lo ? lob : old_ir[7:0]));
                @(negedge clk);
                chk("rst_idle", 44'(obs_vec()), 44'd0);
                return;
            end
            bus.Start = (nz && c <= n) ? 1'($urandom) : 1'b0;
            @(negedge clk);
        end
        exp_pc = p + (lo_ok ? (hi_ok ? 16'd2 : 16'd1) : 16'd0);
        exp_ir = !lo_ok ? old_ir : {hi_ok ? hib : old_ir[15:8], lob};
        chk($sformatf("pc@%h", p), 64'(pc_m), 64'(exp_pc));
        chk($sformatf("ir@%h", p), 64'(ir_m), 64'(exp_ir));
        if (lo_ok) last_b = hi_ok ? hib : lob;
    endtask

    initial begin
        int wl, wh;
        bus.Start = 1'b0;
        for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
        mem[16'h0040] = 8'h34;
        mem[16'h0041] = 8'h12;
        #3 chk("reset_outs", 44'(obs_vec()), 44'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("idle", 44'(obs_vec()), 44'(exp_vec(0, 16'h0000, 8'h00)));
        end
        fetch(16'h0040, 0, 0, 1'b0, 0);    // zero wait: Done in cycle 5
        fetch(16'h0040, 3, 3, 1'b0, 0);    // wait states: Done in cycle 11
        fetch(16'h1000, 1, 99, 1'b0, 0);   // high byte times out
        fetch(16'h2000, 99, 0, 1'b0, 0);   // low byte times out
        fetch(16'hFFFF, 0, 1, 1'b1, 0);    // wrap, with Start/ack interference
        fetch(16'h3000, 0, 2, 1'b0, 3);    // reset while in REQ_HI
        fetch(pc_m, 1, 0, 1'b0, 0);        // fetch from the current PC after reset
        repeat (25) begin
            wl = ($urandom_range(0, 7) == 0) ? 99 : int'($urandom_range(0, 4));
            wh = ($urandom_range(0, 7) == 0) ? 99 : int'($urandom_range(0, 4));
            fetch(16'($urandom), wl, wh, 1'b1, 0);
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/instr_fetch_sequencer.md
Name: instr_fetch_sequencer

Overview:
- Upstream stage that fills the 16-bit instruction register from byte-wide memory.
- Fetches two bytes at PC and PC+1 (low byte first, little-endian) through a req/ack handshake.
- Drives the instruction register's load controls to write each byte: FunSel 101 loads the low byte, FunSel 110 loads the high byte.
- Drives the PC register's load controls to increment PC after each byte (FunSel 001).
- Reports Busy, Done and Timeout to the control unit.

Parameters:
TIMEOUT, 15, max cycles waiting for MemAck per byte; 0 disables timeout
CNT_W, 4, width of timeout counter; must hold TIMEOUT

Ports:
Clock  input  1  system clock, rising edge
Reset  input  1  asynchronous, active-low reset
Start  input  1  request one instruction fetch; sampled only in IDLE
PC  input  16  current PC register Q
MemData  input  8  memory read byte, valid when MemAck=1
MemAck  input  1  memory acknowledge, one-cycle pulse per request
MemAddr  output  16  memory address
MemReq  output  1  memory read request
IR_I  output  16  instruction register data, {8'h00, captured byte}
IR_FunSel  output  3  instruction register function select
IR_E  output  1  instruction register enable
PC_FunSel  output  3  PC register function select
PC_E  output  1  PC register enable
Busy  output  1  high in any state other than IDLE
Done  output  1  one-cycle pulse, fetch complete
Timeout  output  1  one-cycle pulse, fetch aborted

Behaviour:
- Clocking and reset:
  - One clock domain.
  - Reset=0 asynchronously forces state IDLE, captured byte 8'h00, counter 0.
  - Reset=0 forces all outputs to 0: MemAddr=0, FunSels=3'b000, enables low, MemReq/Busy/Done/Timeout low.
  - Reset asserted mid-fetch aborts the fetch with no further IR/PC writes and no Done.
- State register is one-hot or binary (implementer's choice). States: IDLE, REQ_LO, LOAD_LO, REQ_HI, LOAD_HI, DONE, ABORT.
- IDLE:
  - Start=1 -> REQ_LO.
  - Start in any other state is ignored; it is not queued.
- REQ_LO and REQ_HI:
  - MemReq=1 and MemAddr=PC (combinational from the PC input).
  - On MemAck=1 (same-cycle ack allowed), latch MemData and go to LOAD_LO or LOAD_HI respectively.
  - Otherwise increment the counter.
  - If TIMEOUT!=0 and the counter reaches TIMEOUT with no ack -> ABORT.
  - Counter clears on entry to each REQ state.
- MemAck in any non-REQ state is ignored and its data discarded.
- LOAD_LO: IR_E=1, IR_FunSel=101, PC_E=1, PC_FunSel=001 for exactly one cycle -> REQ_HI.
- LOAD_HI: IR_E=1, IR_FunSel=110, PC_E=1, PC_FunSel=001 for exactly one cycle -> DONE.
- Ordering: PC updates at the LOAD_LO edge, so REQ_HI presents the incremented PC with no internal adder.
- DONE: Done=1 for one cycle -> IDLE.
- ABORT: Timeout=1 for one cycle -> IDLE.
  - No IR/PC write for the missing byte.
  - An already-loaded low byte and PC+1 remain.
- Output defaults: when an enable is 0, its FunSel=3'b000. MemAddr=0 and MemReq=0 outside REQ states.
- IR_I[15:8] is always 8'h00. IR_I[7:0] is the latched byte, held until the next ack.
- Wrap-around: PC=16'hFFFF fetches FFFF then 0000 (PC register wraps).
- Latency with zero-wait memory (Start sampled at edge 0):
  - REQ_LO in cycle 1, LOAD_LO in cycle 2, REQ_HI in cycle 3, LOAD_HI in cycle 4, Done in cycle 5.
  - Total is 5 + wait cycles.
- Start is accepted again in the cycle after Done.

Test Plan:
- Reset then idle: Reset=0 mid-cycle -> all outputs 0 immediately (asynchronous); Reset=1, Start=0 -> Busy=0, no MemReq.
- Zero-wait fetch: PC=16'h0040, mem[0040]=8'h34, mem[0041]=8'h12, MemAck same cycle as MemReq -> MemAddr 0040 then 0041; IR FunSel 101/110 with IR_I 0034/0012; IR Q=16'h1234, PC=16'h0042; Done in cycle 5.
- Wait states: 3-cycle MemAck delay on both bytes -> MemReq held steady throughout; Done in cycle 11; same IR/PC result.
- Timeout on high byte: TIMEOUT=15, no ack for the second byte -> after 15 REQ_HI cycles, Timeout pulse, no LOAD_HI, PC=start+1, IR low byte loaded, back to IDLE.
- Wrap and interference: PC=16'hFFFF -> addresses FFFF then 0000, final PC=16'h0001; Start pulses and spurious MemAck during LOAD/DONE states are ignored.
- Reset mid-fetch: Reset=0 during REQ_HI -> no Done/IR_E afterwards; a new Start after release fetches from the current PC.
